// File: rtl/ncpu32k_regfile_mp.sv
`default_nettype none
//==============================================================================
// Module   : ncpu32k_regfile_mp
// Brief    : Multi-port GPR file with hardwired-zero entry 0 and a post-reset
//            clear sequencer. Optional same-edge bypass: NCPU_REGF_BYPASS_EN.
// Revision : 1.0
//==============================================================================
module ncpu32k_regfile_mp #(
    parameter int AW  = 5,
    parameter int DW  = 32,
    parameter int NRD = 2,
    parameter int NWR = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_re,
    output logic [NRD*DW-1:0] rd_dout,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_din,
    input  logic [NWR-1:0]    wr_we
);

    localparam int          c_DEPTH    = 1 << AW;
    localparam logic [AW-1:0] c_CNT_LAST = '1;

    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_READY = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic          r_init_busy;
    logic          w_busy_nxt;
    logic          w_clear_we;
    logic          w_norm_op;
    logic [DW-1:0] r_mem [c_DEPTH];

    // Sequencer: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RESET: w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_READY;
            c_ST_READY: w_state_nxt = c_ST_READY;
            default:    w_state_nxt = c_ST_RESET;
        endcase
    end

    // Sequencer: outputs
    always_comb begin
        w_clear_we = !rst && (r_state == c_ST_CLEAR);
        w_norm_op  = !rst && (r_state == c_ST_READY);
        w_busy_nxt = (w_state_nxt != c_ST_READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_busy <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_init_busy <= w_busy_nxt;
            if (w_clear_we) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign init_busy = r_init_busy;

    // Ascending port loop: the last (highest-index) assignment to an entry wins.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_norm_op) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_we[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    r_mem[wr_addr[j*AW +: AW]] <= wr_din[j*DW +: DW];
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic [DW-1:0] w_data;
            logic [DW-1:0] r_dout;

            assign w_addr = rd_addr[i*AW +: AW];

`ifdef NCPU_REGF_BYPASS_EN
            always_comb begin
                w_data = r_mem[w_addr];
                for (int j = 0; j < NWR; j++) begin
                    if (wr_we[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
                        w_data = wr_din[j*DW +: DW];
                    end
                end
                if (w_addr == '0) begin
                    w_data = '0;
                end
            end
`else
            always_comb begin
                w_data = (w_addr == '0) ? '0 : r_mem[w_addr];
            end
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_norm_op && rd_re[i]) begin
                    r_dout <= w_data;
                end
            end

            assign rd_dout[i*DW +: DW] = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ncpu32k_regfile_mp.sv
`default_nettype none
//==============================================================================
// Module   : tb_ncpu32k_regfile_mp
// Brief    : Randomised and directed bench for ncpu32k_regfile_mp against an
//            array-based reference model.
// Revision : 1.0
//==============================================================================
module tb_ncpu32k_regfile_mp;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_busy;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_re;
    logic [NRD*DW-1:0] rd_dout;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_din;
    logic [NWR-1:0]    wr_we;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_dout [NRD];
    logic          m_busy;
    logic          m_in_rst;
    int            m_edges;

    ncpu32k_regfile_mp #(.AW(AW), .DW(DW), .NRD(NRD), .NWR(NWR)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .rd_addr   (rd_addr),
        .rd_re     (rd_re),
        .rd_dout   (rd_dout),
        .wr_addr   (wr_addr),
        .wr_din    (wr_din),
        .wr_we     (wr_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int a;
        logic [DW-1:0] v;
        if (rst) begin
            m_in_rst = 1'b1;
            m_busy   = 1'b1;
            m_edges  = 0;
            for (int i = 0; i < NRD; i++) m_dout[i] = '0;
        end else if (m_in_rst) begin
            m_in_rst = 1'b0;
            m_edges  = 0;
        end else if (m_busy) begin
            m_edges++;
            if (m_edges == DEPTH) begin
                m_busy = 1'b0;
                for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_re[i]) begin
                    a = int'(rd_addr[i*AW +: AW]);
                    v = (a == 0) ? '0 : m_mem[a];
`ifdef NCPU_REGF_BYPASS_EN
                    for (int j = 0; j < NWR; j++)
                        if (wr_we[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a)
                            v = wr_din[j*DW +: DW];
`endif
                    m_dout[i] = v;
                end
            end
            for (int j = 0; j < NWR; j++)
                if (wr_we[j] && wr_addr[j*AW +: AW] != '0)
                    m_mem[wr_addr[j*AW +: AW]] = wr_din[j*DW +: DW];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("init_busy", {31'd0, init_busy}, {31'd0, m_busy});
        for (int i = 0; i < NRD; i++)
            chk($sformatf("rd_dout%0d", i), rd_dout[i*DW +: DW], m_dout[i]);
    endtask

    task automatic idle();
        rd_re = '0;
        wr_we = '0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_we[p]          = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_din[p*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_re[p]            = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) tick();
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic [DW-1:0] same_edge_exp;
        rst = 1'b1; rd_addr = '0; rd_re = '0; wr_addr = '0; wr_din = '0; wr_we = '0;
        m_in_rst = 1'b1; m_busy = 1'b1; m_edges = 0;
        for (int i = 0; i < NRD; i++) m_dout[i] = '0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 'x;

        // Reset, then clear with random traffic that must be ignored
        do_reset(3);
        busy_cnt = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            rd_re = NRD'($urandom); wr_we = NWR'($urandom);
            rd_addr = NRD*AW'($urandom); wr_addr = NWR*AW'($urandom);
            wr_din = {$urandom, $urandom};
            tick();
            if (init_busy) busy_cnt++;
        end
        chk("busy_len", DW'(busy_cnt), DW'(DEPTH));
        idle();

        for (int a = 0; a < DEPTH; a += NRD) begin
            for (int p = 0; p < NRD; p++) set_rd(p, a + p);
            tick();
        end
        idle();

        // Write then read, then hold
        set_wr(0, 5, 32'hDEADBEEF); tick(); idle();
        set_rd(1, 5); tick(); idle();
        chk("rd5", rd_dout[DW +: DW], 32'hDEADBEEF);
        rd_re[1] = 1'b0; rd_addr[AW +: AW] = 5'd6; tick();
        chk("hold5", rd_dout[DW +: DW], 32'hDEADBEEF);

        // Collision: highest port wins
        set_wr(0, 7, 32'h11111111); set_wr(1, 7, 32'h22222222); tick(); idle();
        set_rd(0, 7); tick(); idle();
        chk("collide7", rd_dout[0 +: DW], 32'h22222222);

        // Same-edge read/write
        set_wr(0, 9, 32'hA); tick(); idle();
        set_wr(1, 9, 32'hB); set_rd(0, 9); tick(); idle();
`ifdef NCPU_REGF_BYPASS_EN
        same_edge_exp = 32'hB;
`else
        same_edge_exp = 32'hA;
`endif
        chk("same_edge9", rd_dout[0 +: DW], same_edge_exp);
        set_rd(0, 9); tick(); idle();
        chk("after9", rd_dout[0 +: DW], 32'hB);

        // Register zero
        set_wr(0, 0, 32'hFFFFFFFF); set_wr(1, 0, 32'hFFFFFFFF); set_rd(0, 0); tick(); idle();
        chk("zero_same", rd_dout[0 +: DW], 32'h0);
        set_rd(1, 0); tick(); idle();
        chk("zero_later", rd_dout[DW +: DW], 32'h0);

        // Randomised traffic on a narrow address window to force collisions
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NRD; p++) begin
                rd_re[p] = 1'($urandom);
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            for (int p = 0; p < NWR; p++) begin
                wr_we[p] = 1'($urandom);
                wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
                wr_din[p*DW +: DW] = $urandom;
            end
            tick();
        end
        idle();

        // Reset in the middle of CLEAR
        set_wr(0, 3, 32'h55); tick(); idle();
        do_reset(2);
        for (int c = 0; c < 10; c++) tick();
        do_reset(1);
        busy_cnt = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            tick();
            if (init_busy) busy_cnt++;
        end
        chk("busy_restart", DW'(busy_cnt), DW'(DEPTH));
        set_rd(1, 3); tick(); idle();
        chk("rd3_cleared", rd_dout[DW +: DW], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
